// File: rtl/alu_mc_if.sv
// Start/busy/done handshake and operand/result bus of the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] E;
  logic [WIDTH-1:0] E_hi;
  logic [3:0]       psr;

  modport master (output start, op, A, B, Cn, input busy, done, E, E_hi, psr);
  modport slave  (input start, op, A, B, Cn, output busy, done, E, E_hi, psr);
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU: 1-cycle add/logic, bit-serial shifts,
// shift-add unsigned multiplier, registered C/N/Z/V flag word.
module alu_mc #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [SW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] e_q, ehi_q;
  logic [3:0]       psr_q;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q;
  logic             cn_q, c_q;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum, mul_sum;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
  logic [WIDTH-1:0] e_d, ehi_d;
  logic             c_d, v_d;
  logic [3:0]       psr_d;

  // Remaining RUN cycles after the accept edge; the last one writes the result.
  function automatic logic [SW-1:0] run_cnt(input logic [2:0] op, input logic [WIDTH-1:0] b);
    logic [SW-1:0] n;
    n = '0;
    case (op)
      OP_SHL, OP_SHR: n = b[SW-1:0];
      OP_MUL:         n = MUL_EN ? SW'(WIDTH - 1) : '0;
      default:        n = '0;
    endcase
    return n;
  endfunction

  assign accept = bus.start && (state_q != RUN);

  always_comb begin
    b_eff    = (op_q == OP_SUB) ? ~b_q : b_q;
    sum      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cn_q};
    mul_sum  = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_hi_d = mul_sum[WIDTH:1];
    mul_lo_d = {mul_sum[0], b_q[WIDTH-1:1]};
    e_d      = '0;
    ehi_d    = '0;
    c_d      = 1'b0;
    v_d      = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        e_d = sum[WIDTH-1:0];
        c_d = sum[WIDTH];
        v_d = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: e_d = a_q & b_q;
      OP_OR:  e_d = a_q | b_q;
      OP_XOR: e_d = a_q ^ b_q;
      OP_SHL, OP_SHR: begin
        e_d = a_q;
        c_d = c_q;
      end
      default: begin
        if (MUL_EN) begin
          e_d   = mul_lo_d;
          ehi_d = mul_hi_d;
          c_d   = |mul_hi_d;
          v_d   = |mul_hi_d;
        end
      end
    endcase
    psr_d = {v_d, (e_d == '0) && (ehi_d == '0), e_d[WIDTH-1], c_d};
  end

  // Operand/working registers: a_q shifts, {hi_q,b_q} is the product register.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.op;
      a_q  <= bus.A;
      b_q  <= bus.B;
      cn_q <= bus.Cn;
      hi_q <= '0;
      c_q  <= 1'b0;
    end else if (state_q == RUN && cnt_q != '0) begin
      case (op_q)
        OP_SHL: begin a_q <= a_q << 1; c_q <= a_q[WIDTH-1]; end
        OP_SHR: begin a_q <= a_q >> 1; c_q <= a_q[0]; end
        OP_MUL: begin hi_q <= mul_hi_d; b_q <= mul_lo_d; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      e_q     <= '0;
      ehi_q   <= '0;
      psr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (cnt_q == '0) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            e_q     <= e_d;
            ehi_q   <= ehi_d;
            psr_q   <= psr_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= run_cnt(bus.op, bus.B);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.E    = e_q;
  assign bus.E_hi = ehi_q;
  assign bus.psr  = psr_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8, with MUL_EN=1 and MUL_EN=0 instances.
module tb_alu_mc;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc_if #(.WIDTH(8)) if0 ();
  alu_mc_if #(.WIDTH(8)) if1 ();

  alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) u_mul (.clk(clk), .reset(reset), .bus(if0));
  alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) u_nomul (.clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    string      name;
    logic [7:0] e;
    logic [7:0] ehi;
    logic [3:0] psr;
    int         t0;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t x0, x1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (if0.done === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected done: E=%h E_hi=%h psr=%b", if0.E, if0.E_hi, if0.psr);
      end else begin
        x0 = q0.pop_front();
        chk({x0.name, " E"}, if0.E, x0.e);
        chk({x0.name, " E_hi"}, if0.E_hi, x0.ehi);
        chk({x0.name, " psr"}, if0.psr, x0.psr);
        chk({x0.name, " latency"}, cyc - x0.t0, x0.lat);
      end
    end
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected done: E=%h E_hi=%h psr=%b", if1.E, if1.E_hi, if1.psr);
      end else begin
        x1 = q1.pop_front();
        chk({x1.name, " E"}, if1.E, x1.e);
        chk({x1.name, " E_hi"}, if1.E_hi, x1.ehi);
        chk({x1.name, " psr"}, if1.psr, x1.psr);
        chk({x1.name, " latency"}, cyc - x1.t0, x1.lat);
      end
    end
  end

  task automatic drive(input int sel, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cn);
    if (sel == 0) begin
      if0.start = 1'b1; if0.op = op; if0.A = a; if0.B = b; if0.Cn = cn;
    end else begin
      if1.start = 1'b1; if1.op = op; if1.A = a; if1.B = b; if1.Cn = cn;
    end
  endtask

  task automatic push(input int sel, input string name, input logic [7:0] e,
                      input logic [7:0] ehi, input logic [3:0] psr, input int lat);
    exp_t x;
    x.name = name; x.e = e; x.ehi = ehi; x.psr = psr; x.lat = lat;
    x.t0 = cyc + 1;
    if (sel == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic wait_empty(input int sel);
    for (int i = 0; i < 60; i++) begin
      if ((sel == 0 ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    if ((sel == 0 ? q0.size() : q1.size()) != 0) begin
      checks++; errors++;
      $display("FAIL dut%0d timeout: no done, pending=%0d required=0", sel,
               (sel == 0 ? q0.size() : q1.size()));
      if (sel == 0) q0.delete();
      else q1.delete();
    end
  endtask

  task automatic run(input int sel, input string name, input logic [2:0] op,
                     input logic [7:0] a, input logic [7:0] b, input logic cn,
                     input logic [7:0] e, input logic [7:0] ehi, input logic [3:0] psr,
                     input int lat);
    drive(sel, op, a, b, cn);
    push(sel, name, e, ehi, psr, lat);
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    wait_empty(sel);
  endtask

  initial begin
    bit seen;
    if0.start = 1'b0; if0.op = '0; if0.A = '0; if0.B = '0; if0.Cn = 1'b0;
    if1.start = 1'b0; if1.op = '0; if1.A = '0; if1.B = '0; if1.Cn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", if0.busy, 1'b0);
    chk("reset done", if0.done, 1'b0);
    chk("reset E", if0.E, 8'h00);
    chk("reset E_hi", if0.E_hi, 8'h00);
    chk("reset psr", if0.psr, 4'b0000);
    reset = 1'b1;
    @(negedge clk);

    run(0, "add overflow", ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 4'b1010, 1);

    // SUB, then a back-to-back ADD issued in the done cycle
    drive(0, SUB, 8'h05, 8'h05, 1'b1);
    push(0, "sub zero", 8'h00, 8'h00, 4'b0101, 1);
    @(negedge clk);
    if0.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if0.done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("sub done seen", seen, 1'b1);
    drive(0, ADD, 8'h10, 8'h20, 1'b1);
    push(0, "add back-to-back", 8'h31, 8'h00, 4'b0000, 1);
    @(negedge clk);
    if0.start = 1'b0;
    chk("b2b busy", if0.busy, 1'b1);
    wait_empty(0);

    // MUL with an ignored start and operand change mid-op
    drive(0, MUL, 8'hFF, 8'hFF, 1'b0);
    push(0, "mul ff*ff", 8'h01, 8'hFE, 4'b1001, 8);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (2) @(negedge clk);
    drive(0, ADD, 8'h01, 8'h01, 1'b0);
    @(negedge clk);
    if0.start = 1'b0; if0.A = 8'h00; if0.B = 8'h00;
    chk("mul busy mid-op", if0.busy, 1'b1);
    chk("E held mid-op", if0.E, 8'h31);
    wait_empty(0);

    run(0, "shl 81 by 3", SHL, 8'h81, 8'h03, 1'b0, 8'h08, 8'h00, 4'b0000, 4);
    run(0, "shl 81 by 1", SHL, 8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 4'b0001, 2);
    run(0, "shr 81 by 0", SHR, 8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 4'b0010, 1);
    run(0, "shr 83 by 2", SHR, 8'h83, 8'h02, 1'b0, 8'h20, 8'h00, 4'b0001, 3);
    run(0, "shl 01 by B=0a", SHL, 8'h01, 8'h0A, 1'b0, 8'h04, 8'h00, 4'b0000, 3);
    run(0, "and", AND_, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 4'b0000, 1);
    run(0, "or", OR_, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'h00, 4'b0010, 1);
    run(0, "xor", XOR_, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 4'b0100, 1);
    run(0, "sub borrow", SUB, 8'h00, 8'h01, 1'b1, 8'hFF, 8'h00, 4'b0010, 1);
    run(0, "add carry", ADD, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 4'b1101, 1);
    run(0, "sub overflow", SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 8'h00, 4'b1001, 1);
    run(0, "mul 10*10", MUL, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 4'b1001, 8);
    run(0, "mul 11*11", MUL, 8'h11, 8'h11, 1'b0, 8'h21, 8'h01, 4'b1001, 8);

    // Reset in the middle of a MUL: outputs clear at once, no done follows
    drive(0, MUL, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", if0.busy, 1'b0);
    chk("abort E", if0.E, 8'h00);
    chk("abort E_hi", if0.E_hi, 8'h00);
    chk("abort psr", if0.psr, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    run(0, "add after reset", ADD, 8'h02, 8'h03, 1'b0, 8'h05, 8'h00, 4'b0000, 1);

    run(1, "nomul op7", MUL, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 4'b0100, 1);
    run(1, "nomul add", ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 4'b1010, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
